pc_next_unit: RTL and testbench

- Program-counter register with integrated next-PC datapath for the single-cycle RV32 core.
- Two 2:1 operand muxes feed a BITWIDTH-bit adder. A 4-way select then chooses the adder result, the trap vector (mtvec) or the exception return address (mepc) as the next PC.
- Sits between the decoder/CSR file (select and operand sources) and instruction fetch (consumes pc).

---
 rtl/pc_next_unit.sv | 140 ++++++++++++++
 tb/tb_pc_next_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter register and next-PC datapath for the
// single-cycle RV32 core.
//
// Contents: a generic 2:1 mux, a per-bit full adder, a ripple-carry adder
// built from those full adders, and the top module.
//
// Optional feature: define PC_JALR_LSB_CLR_EN to clear bit 0 of the adder
// result whenever operand A comes from rs1 (JALR target semantics).
// With the macro undefined, odd rs1-based targets pass through unchanged.

// Generic 2:1 mux: result = s ? input2 : input1
module pc_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             s,
  output logic [WIDTH-1:0] result
);
  assign result = s ? input2 : input1;
endmodule

// Single-bit full adder
module pc_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Ripple-carry adder; cout is the carry out of the MSB
module pc_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pc_full_adder u_fa (
        .a    (augend[gi]),
        .b    (addend[gi]),
        .cin  (carry[gi]),
        .sum  (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign cout = carry[WIDTH];
endmodule

// Top: operand muxes -> adder -> 4-way next-PC select -> pc register.
// imm, mtvec and mepc are 32 bits, so BITWIDTH must stay 32.
module pc_next_unit #(
  parameter int                BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] RST_VALUE = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] rs1_data,
  input  logic [31:0]         imm,
  input  logic [31:0]         mtvec,
  input  logic [31:0]         mepc,
  input  logic [1:0]          pc_sel,
  input  logic [1:0]          adder_sel,
  output logic [BITWIDTH-1:0] pc
);
  logic [BITWIDTH-1:0] pc_reg;
  logic [BITWIDTH-1:0] pc_next;
  logic [BITWIDTH-1:0] op_a;
  logic [BITWIDTH-1:0] op_b;
  logic [BITWIDTH-1:0] adder_sum;
  logic [BITWIDTH-1:0] adder_target;
  logic                unused_cout;

  // Operand A: current pc for PC-relative flow, rs1 for JALR
  pc_mux2 #(.WIDTH(BITWIDTH)) u_mux_a (
    .input1 (pc_reg),
    .input2 (rs1_data),
    .s      (adder_sel[1]),
    .result (op_a)
  );

  // Operand B: sequential increment of 4, or the immediate
  pc_mux2 #(.WIDTH(BITWIDTH)) u_mux_b (
    .input1 (BITWIDTH'(4)),
    .input2 (imm),
    .s      (adder_sel[0]),
    .result (op_b)
  );

  // Carry-in unused here; carry-out is dropped since wrap-around is silent
  pc_adder #(.WIDTH(BITWIDTH)) u_adder (
    .augend (op_a),
    .addend (op_b),
    .cin    (1'b0),
    .sum    (adder_sum),
    .cout   (unused_cout)
  );

`ifdef PC_JALR_LSB_CLR_EN
  // rs1-based targets get bit 0 cleared, as JALR requires
  assign adder_target = adder_sel[1] ? {adder_sum[BITWIDTH-1:1], 1'b0} : adder_sum;
`else
  assign adder_target = adder_sum;
`endif

  // Next-PC select; the reserved code 2'b10 falls back to the adder result
  always_comb begin
    pc_next = adder_target;
    case (pc_sel)
      2'b01:   pc_next = mtvec;
      2'b11:   pc_next = mepc;
      default: pc_next = adder_target;
    endcase
  end

  // PC register: reset vector wins over every select value
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RST_VALUE;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed testbench for pc_next_unit, plus standalone checks of the
// adder and mux submodules. Honours PC_JALR_LSB_CLR_EN when defined.
`timescale 1ns/1ps

module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1_data;
  logic [31:0] imm;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [1:0]  pc_sel;
  logic [1:0]  adder_sel;
  logic [31:0] pc;

  // standalone adder
  logic [31:0] a_aug, a_add, a_sum;
  logic        a_cin, a_cout;

  // standalone mux
  logic [31:0] m_in1, m_in2, m_res;
  logic        m_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.BITWIDTH(32), .RST_VALUE(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_data  (rs1_data),
    .imm       (imm),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .pc_sel    (pc_sel),
    .adder_sel (adder_sel),
    .pc        (pc)
  );

  pc_adder #(.WIDTH(32)) u_add (
    .augend (a_aug),
    .addend (a_add),
    .cin    (a_cin),
    .sum    (a_sum),
    .cout   (a_cout)
  );

  pc_mux2 #(.WIDTH(32)) u_mux (
    .input1 (m_in1),
    .input2 (m_in2),
    .s      (m_s),
    .result (m_res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    $display("check %-14s got=%h exp=%h", tag, got, exp);
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one clock edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] jalr_exp;
  logic [31:0] jalr2_exp;
  logic [31:0] mexp;

  initial begin
`ifdef PC_JALR_LSB_CLR_EN
    jalr_exp  = 32'h1000_0004;
    jalr2_exp = 32'h1000_0004;
`else
    jalr_exp  = 32'h1000_0005;
    jalr2_exp = 32'h1000_0005;
`endif
    rst = 1'b1; rs1_data = '0; imm = '0; mtvec = '0; mepc = '0;
    pc_sel = 2'b00; adder_sel = 2'b00;
    a_aug = '0; a_add = '0; a_cin = 1'b0;
    m_in1 = '0; m_in2 = '0; m_s = 1'b0;

    // reset held for two edges
    step(); step();
    check("reset", pc, 32'h8000_0000);
    rst = 1'b0;
    step(); check("seq_4", pc, 32'h8000_0004);
    step(); check("seq_8", pc, 32'h8000_0008);
    step(); step(); check("seq_10", pc, 32'h8000_0010);

    // branch/JAL: pc + imm
    adder_sel = 2'b01; imm = 32'hFFFF_FFF0;
    step(); check("br_neg", pc, 32'h8000_0000);
    imm = 32'h0000_0010;
    step(); check("br_pos16", pc, 32'h8000_0010);
    imm = 32'h0000_0100;
    step(); check("br_pos100", pc, 32'h8000_0110);

    // JALR: rs1 + imm with odd rs1
    adder_sel = 2'b11; rs1_data = 32'h1000_0001; imm = 32'h0000_0004;
    step(); check("jalr", pc, jalr_exp);
    // rs1 + 4 path also counts as rs1-based
    adder_sel = 2'b10; rs1_data = 32'h1000_0001;
    step(); check("rs1_plus4", pc, jalr2_exp);
    // pc-relative path with odd imm is never masked
    adder_sel = 2'b01; rs1_data = '0; imm = 32'h0000_0001;
    step(); check("pc_odd_imm", pc, jalr2_exp + 32'h1);

    // trap entry and return
    pc_sel = 2'b01; mtvec = 32'h8000_0100;
    step(); check("trap", pc, 32'h8000_0100);
    pc_sel = 2'b11; mepc = 32'h8000_0044;
    step(); check("mret", pc, 32'h8000_0044);
    pc_sel = 2'b10; adder_sel = 2'b00;
    step(); check("reserved", pc, 32'h8000_0048);
    // unaligned mtvec loaded verbatim
    pc_sel = 2'b01; mtvec = 32'h8000_0103;
    step(); check("mtvec_odd", pc, 32'h8000_0103);

    // wrap-around via rs1 and via pc
    pc_sel = 2'b00; adder_sel = 2'b10; rs1_data = 32'hFFFF_FFFC;
    step(); check("wrap_rs1", pc, 32'h0000_0000);
    pc_sel = 2'b01; mtvec = 32'hFFFF_FFFC;
    step(); check("load_top", pc, 32'hFFFF_FFFC);
    pc_sel = 2'b00; adder_sel = 2'b00;
    step(); check("wrap_pc", pc, 32'h0000_0000);

    // inputs glitching between edges have no effect
    #2 pc_sel = 2'b01; mtvec = 32'hDEAD_BEEF;
    #2 pc_sel = 2'b00;
    step(); check("glitch", pc, 32'h0000_0004);

    // reset priority over trap select
    rst = 1'b1; pc_sel = 2'b01; mtvec = 32'h1234_5678;
    step(); check("rst_prio_01", pc, 32'h8000_0000);
    pc_sel = 2'b11; mepc = 32'h0000_0ABC;
    step(); check("rst_prio_11", pc, 32'h8000_0000);
    rst = 1'b0; pc_sel = 2'b00; adder_sel = 2'b00;
    step(); check("rst_release", pc, 32'h8000_0004);

    // standalone adder
    a_aug = 32'hFFFF_FFFF; a_add = 32'h0000_0001; a_cin = 1'b0;
    #1 check("add1_sum", a_sum, 32'h0000_0000);
    check("add1_cout", {31'b0, a_cout}, 32'h1);
    a_aug = 32'h7FFF_FFFF; a_add = 32'h0000_0001; a_cin = 1'b1;
    #1 check("add2_sum", a_sum, 32'h8000_0001);
    check("add2_cout", {31'b0, a_cout}, 32'h0);
    a_aug = 32'h1234_5678; a_add = 32'h1111_1111; a_cin = 1'b0;
    #1 check("add3_sum", a_sum, 32'h2345_6789);
    a_aug = 32'hFFFF_FFFF; a_add = 32'hFFFF_FFFF; a_cin = 1'b1;
    #1 check("add4_sum", a_sum, 32'hFFFF_FFFF);
    check("add4_cout", {31'b0, a_cout}, 32'h1);

    // standalone mux on random vectors
    for (int i = 0; i < 16; i++) begin
      m_in1 = $urandom; m_in2 = $urandom; m_s = i[0];
      mexp = m_s ? m_in2 : m_in1;
      #1 check("mux_rand", m_res, mexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
